// File: rtl/selu_pkg.sv
// rtl/selu_pkg.sv - shared parameters for the SELU activation arbiter
package selu_pkg;

   localparam int SELU_N_CH    = 4;
   localparam int SELU_ACT_LAT = 2;
   localparam int SELU_DATA_W  = 8;
   localparam int SELU_CH_W    = $clog2(SELU_N_CH);

   // Index width that stays legal for a single-channel build.
   function automatic int selu_idx_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/selu_act_arbiter_rr.sv
// rtl/selu_act_arbiter_rr.sv - combinational round-robin grant, searching from i_last+1
module rr_arbiter
   import selu_pkg::*;
#(
   parameter int N = SELU_N_CH,
   parameter int W = SELU_CH_W
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_last,
   output logic [N-1:0] o_grant,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);

   // Indices above i_last win first, then wrap to 0..i_last.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!o_valid && i_req[j] && (j > int'(i_last))) begin
            o_valid    = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = W'(j);
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!o_valid && i_req[j] && (j <= int'(i_last))) begin
            o_valid    = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = W'(j);
         end
      end
   end

endmodule

// File: rtl/selu_act_arbiter.sv
// rtl/selu_act_arbiter.sv - shares one fixed-latency activation unit among N_CH channels
module selu_act_arbiter
   import selu_pkg::*;
#(
   parameter int N_CH    = SELU_N_CH,
   parameter int ACT_LAT = SELU_ACT_LAT,
   parameter int DATA_W  = SELU_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          ch_in_valid,
   input  logic [N_CH*DATA_W-1:0]   ch_in_data,
   output logic [N_CH-1:0]          ch_in_ready,
   input  logic                     flush,
   output logic                     act_in_valid,
   output logic [DATA_W-1:0]        act_in_data,
   input  logic                     act_out_valid,
   input  logic [DATA_W-1:0]        act_out_data,
   output logic [N_CH-1:0]          ch_out_valid,
   output logic [DATA_W-1:0]        ch_out_data,
   output logic                     idle,
   output logic                     err
);

   localparam int              CH_W     = selu_idx_w(N_CH);
   localparam logic [CH_W-1:0] LAST_RST = CH_W'(N_CH - 1);

   logic [N_CH-1:0]              r_full;
   logic [N_CH-1:0][DATA_W-1:0]  r_buf;
   logic [CH_W-1:0]              r_last;
   logic                         r_act_v;
   logic [DATA_W-1:0]            r_act_data;
   logic [CH_W-1:0]              r_act_ch;
   logic [ACT_LAT-1:0]           r_tag_v;
   logic [ACT_LAT-1:0][CH_W-1:0] r_tag_ch;
   logic [N_CH-1:0]              r_out_v;
   logic [DATA_W-1:0]            r_out_data;
   logic                         r_err;

   logic [N_CH-1:0] w_hs;
   logic [N_CH-1:0] w_gnt;
   logic [CH_W-1:0] w_gnt_idx;
   logic            w_gnt_v;
   logic            w_issue;
   logic            w_exit_v;
   logic [CH_W-1:0] w_exit_ch;
   logic            w_deliver;
   logic [N_CH-1:0] w_exit_onehot;

   // rst_n is the active-high reset; ready must also read low while it is held.
   assign ch_in_ready = ~r_full & {N_CH{~flush & ~rst_n}};
   assign w_hs        = ch_in_valid & ch_in_ready;

   rr_arbiter #(
      .N (N_CH),
      .W (CH_W)
   ) u_rr (
      .i_req   (r_full),
      .i_last  (r_last),
      .o_grant (w_gnt),
      .o_idx   (w_gnt_idx),
      .o_valid (w_gnt_v)
   );

   assign w_issue = w_gnt_v & ~flush;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_full <= '0;
         r_buf  <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (flush) begin
               r_full[k] <= 1'b0;
            end else if (w_hs[k]) begin
               r_full[k] <= 1'b1;
               r_buf[k]  <= ch_in_data[k*DATA_W +: DATA_W];
            end else if (w_issue && w_gnt[k]) begin
               r_full[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_act_v    <= 1'b0;
         r_act_data <= '0;
         r_act_ch   <= '0;
         r_last     <= LAST_RST;
      end else begin
         r_act_v <= w_issue;
         if (w_issue) begin
            r_act_data <= r_buf[w_gnt_idx];
            r_act_ch   <= w_gnt_idx;
            r_last     <= w_gnt_idx;
         end
      end
   end

   // Tags trail the issue register so the last stage lines up with act_out_valid.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_tag_v  <= '0;
         r_tag_ch <= '0;
      end else begin
         r_tag_v[0]  <= r_act_v;
         r_tag_ch[0] <= r_act_ch;
         for (int i = 1; i < ACT_LAT; i++) begin
            r_tag_v[i]  <= r_tag_v[i-1];
            r_tag_ch[i] <= r_tag_ch[i-1];
         end
      end
   end

   assign w_exit_v      = r_tag_v[ACT_LAT-1];
   assign w_exit_ch     = r_tag_ch[ACT_LAT-1];
   assign w_deliver     = act_out_valid & w_exit_v;
   assign w_exit_onehot = N_CH'(1) << w_exit_ch;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_out_v    <= '0;
         r_out_data <= '0;
         r_err      <= 1'b0;
      end else begin
         r_out_v <= w_deliver ? w_exit_onehot : '0;
         if (w_deliver) begin
            r_out_data <= act_out_data;
         end
         r_err <= r_err | (act_out_valid ^ w_exit_v);
      end
   end

   assign act_in_valid = r_act_v;
   assign act_in_data  = r_act_data;
   assign ch_out_valid = r_out_v;
   assign ch_out_data  = r_out_data;
   assign err          = r_err;
   assign idle         = ~|r_full & ~|r_tag_v & ~r_act_v & ~|r_out_v;

endmodule

// File: tb/tb_selu_act_arbiter.sv
// tb/tb_selu_act_arbiter.sv - scoreboard bench for selu_act_arbiter with a 2-cycle SELU LUT model
module tb_selu_act_arbiter;

   localparam int NC = 4;
   localparam int DW = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [NC-1:0]    ch_in_valid = '0;
   logic [NC*DW-1:0] ch_in_data = '0;
   logic [NC-1:0]    ch_in_ready;
   logic             flush = 1'b0;
   logic             act_in_valid;
   logic [DW-1:0]    act_in_data;
   logic             act_out_valid;
   logic [DW-1:0]    act_out_data;
   logic [NC-1:0]    ch_out_valid;
   logic [DW-1:0]    ch_out_data;
   logic             idle;
   logic             err;
   logic             stray_pulse = 1'b0;
   logic             act_rstn;

   always #5 clk = ~clk;

   selu_act_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ch_in_valid   (ch_in_valid),
      .ch_in_data    (ch_in_data),
      .ch_in_ready   (ch_in_ready),
      .flush         (flush),
      .act_in_valid  (act_in_valid),
      .act_in_data   (act_in_data),
      .act_out_valid (act_out_valid),
      .act_out_data  (act_out_data),
      .ch_out_valid  (ch_out_valid),
      .ch_out_data   (ch_out_data),
      .idle          (idle),
      .err           (err)
   );

   function automatic logic [7:0] selu_f(input logic [7:0] x);
      int xs;
      int y;
      xs = int'($signed(x));
      if (xs >= 0) begin
         y = (xs * 269) >>> 8;
         if (y > 127) y = 127;
      end else begin
         y = -(((-xs) * 56) / ((-xs) + 24));
      end
      return 8'(y);
   endfunction

   // Activation unit beside the arbiter: active-low reset, two-cycle delay.
   assign act_rstn = ~rst_n;
   logic          m_v1, m_v2;
   logic [DW-1:0] m_d1, m_d2;
   always @(posedge clk or negedge act_rstn) begin
      if (!act_rstn) begin
         m_v1 <= 1'b0; m_v2 <= 1'b0; m_d1 <= '0; m_d2 <= '0;
      end else begin
         m_v1 <= act_in_valid;
         m_d1 <= selu_f(act_in_data);
         m_v2 <= m_v1;
         m_d2 <= m_d1;
      end
   end
   assign act_out_valid = m_v2 | stray_pulse;
   assign act_out_data  = m_d2;

   typedef struct packed {
      logic [1:0]    ch;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Accepted samples enter the scoreboard; each result must match the oldest entry of its channel.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NC; k++) begin
            if (ch_in_valid[k] && ch_in_ready[k])
               sb.push_back('{ch: 2'(k), data: selu_f(ch_in_data[k*DW +: DW])});
         end
         if (ch_out_valid != '0) begin
            int och;
            int idx;
            och = 0;
            idx = -1;
            chk("out_onehot", $countones(ch_out_valid), 1);
            for (int k = 0; k < NC; k++) if (ch_out_valid[k]) och = k;
            for (int i = 0; i < sb.size(); i++) if (idx < 0 && int'(sb[i].ch) == och) idx = i;
            chk("out_expected", idx >= 0, 1);
            if (idx >= 0) begin
               chk("out_data", ch_out_data, sb[idx].data);
               sb.delete(idx);
            end
         end
      end
   end

   task automatic do_reset(input bit check_state);
      rst_n = 1'b1;
      flush = 1'b0;
      ch_in_valid = '0;
      ch_in_data = '0;
      stray_pulse = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      if (check_state) begin
         @(negedge clk);
         chk("rst_act_v", act_in_valid, 0);
         chk("rst_act_d", act_in_data, 0);
         chk("rst_out_v", ch_out_valid, 0);
         chk("rst_out_d", ch_out_data, 0);
         chk("rst_err", err, 0);
         chk("rst_ready", ch_in_ready, 0);
         chk("rst_idle", idle, 1);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
   endtask

   initial begin
      logic [NC-1:0] hs;
      logic [DW-1:0] d0, d1;

      do_reset(1);

      // Single sample on channel 2
      ch_in_valid = 4'b0100;
      ch_in_data[2*DW +: DW] = 8'h10;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("s1_act_v", act_in_valid, c == 2);
         if (c == 2) chk("s1_act_d", act_in_data, 8'h10);
         chk("s1_out_v", ch_out_valid, (c == 5) ? 4'b0100 : 4'b0000);
         if (c == 5) chk("s1_out_d", ch_out_data, selu_f(8'h10));
         @(posedge clk); #1;
         ch_in_valid = '0;
      end

      // All four channels at once
      do_reset(0);
      ch_in_valid = 4'b1111;
      ch_in_data = {8'h04, 8'h03, 8'h02, 8'h01};
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("s2_act_v", act_in_valid, (c >= 2) && (c <= 5));
         if (c >= 2 && c <= 5) chk("s2_act_d", act_in_data, c - 1);
         chk("s2_out_v", ch_out_valid, (c >= 5 && c <= 8) ? (1 << (c - 5)) : 0);
         @(posedge clk); #1;
         ch_in_valid = '0;
      end

      // ch0 and ch1 streaming back to back
      do_reset(0);
      d0 = 8'h00;
      d1 = 8'h40;
      ch_in_valid = 4'b0011;
      ch_in_data[0 +: DW] = d0;
      ch_in_data[DW +: DW] = d1;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         if (c >= 2 && c <= 15) begin
            chk("s3_act_v", act_in_valid, 1);
            chk("s3_act_d", act_in_data, (((c % 2) != 0) ? 8'h40 : 8'h00) + (c - 2) / 2);
            chk("s3_rdy_alt", ch_in_ready[0] ^ ch_in_ready[1], 1);
         end
         hs = ch_in_valid & ch_in_ready;
         @(posedge clk); #1;
         if (hs[0]) d0 = d0 + 8'd1;
         if (hs[1]) d1 = d1 + 8'd1;
         ch_in_data[0 +: DW] = d0;
         ch_in_data[DW +: DW] = d1;
         ch_in_valid = (c + 1 < 16) ? 4'b0011 : 4'b0000;
      end

      // Flush with two in flight and two buffered
      do_reset(0);
      ch_in_valid = 4'b1111;
      ch_in_data = {8'h24, 8'h23, 8'h22, 8'h21};
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         chk("s4_act_v", act_in_valid, (c == 2) || (c == 3));
         if (c == 2) chk("s4_act_d", act_in_data, 8'h21);
         if (c == 3) chk("s4_act_d", act_in_data, 8'h22);
         if (c == 3) chk("s4_rdy_flush", ch_in_ready, 0);
         chk("s4_out_v", ch_out_valid, (c == 5) ? 4'b0001 : (c == 6) ? 4'b0010 : 4'b0000);
         if (c == 7) chk("s4_idle", idle, 1);
         @(posedge clk); #1;
         ch_in_valid = '0;
         flush = (c + 1 == 3);
         if (c + 1 == 3) begin
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].ch >= 2'd2) sb.delete(i);
         end
      end

      // Reset with three samples in flight
      do_reset(0);
      ch_in_valid = 4'b1111;
      ch_in_data = {8'h34, 8'h33, 8'h32, 8'h31};
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         if (c == 3) chk("s5_act_d", act_in_data, 8'h32);
         if (c >= 4 && c <= 6) begin
            chk("s5_rst_act_v", act_in_valid, 0);
            chk("s5_rst_act_d", act_in_data, 0);
            chk("s5_rst_out_v", ch_out_valid, 0);
            chk("s5_rst_out_d", ch_out_data, 0);
            chk("s5_rst_ready", ch_in_ready, 0);
         end
         if (c >= 4) begin
            chk("s5_out_v", ch_out_valid, 0);
            chk("s5_err", err, 0);
            chk("s5_act_v", act_in_valid, 0);
         end
         @(posedge clk); #1;
         ch_in_valid = '0;
         if (c + 1 == 4) begin
            rst_n = 1'b1;
            sb.delete();
         end
         if (c + 1 == 7) rst_n = 1'b0;
      end

      // Random traffic, samples held until accepted
      do_reset(0);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         hs = ch_in_valid & ch_in_ready;
         @(posedge clk); #1;
         for (int k = 0; k < NC; k++) begin
            if (hs[k] || !ch_in_valid[k]) begin
               ch_in_valid[k] = ($urandom_range(0, 3) != 0);
               ch_in_data[k*DW +: DW] = 8'($urandom);
            end
         end
      end
      ch_in_valid = '0;
      repeat (12) @(negedge clk);
      chk("rnd_idle", idle, 1);
      chk("rnd_err", err, 0);
      chk("rnd_sb_empty", sb.size(), 0);

      // Stray result strobe with nothing in flight
      do_reset(0);
      stray_pulse = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c >= 1) chk("s6_err", err, 1);
         chk("s6_out_v", ch_out_valid, 0);
         @(posedge clk); #1;
         stray_pulse = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/selu_act_arbiter.md
SELU_ACT_ARBITER -- requirements
Module: selu_act_arbiter

Interface
REQ-001 Parameter N_CH, default 4: number of requester channels sharing one SELU LUT activation unit.
REQ-002 Parameter ACT_LAT, default 2: fixed in_valid-to-out_valid latency of the activation unit, in cycles.
REQ-003 Parameter DATA_W, default 8: signed sample width.
REQ-004 clk  input  1  the single clock; all logic is rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-high (1 = reset, despite the name).
REQ-006 ch_in_valid  input  N_CH  per-channel sample offer.
REQ-007 ch_in_data  input  N_CH*DATA_W  per-channel signed samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 ch_in_ready  output  N_CH  per-channel acceptance.
REQ-009 flush  input  1  discard buffered samples and stop new issue.
REQ-010 act_in_valid  output  1  issue strobe to the activation unit.
REQ-011 act_in_data  output  DATA_W  sample sent to the activation unit.
REQ-012 act_out_valid  input  1  result strobe from the activation unit.
REQ-013 act_out_data  input  DATA_W  result from the activation unit.
REQ-014 ch_out_valid  output  N_CH  one-hot result strobe identifying the owning channel.
REQ-015 ch_out_data  output  DATA_W  result data, shared by all channels.
REQ-016 idle  output  1  no buffered, in-flight or pending-output sample.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 Each channel SHALL have a 1-entry holding buffer; ch_in_ready[k] = !full[k] && !flush.
REQ-019 A handshake (valid && ready) at an edge SHALL load the buffer and set full[k].
REQ-020 Each cycle with one or more full buffers and flush low, exactly one channel SHALL be granted, round-robin, searching from last_grant+1 modulo N_CH.
REQ-021 The granted buffer SHALL clear at the same edge that registers act_in_valid=1 and act_in_data=buffer; last_grant SHALL update to the granted index.
REQ-022 With no grant in a cycle, act_in_valid SHALL be 0 in the next cycle; act_in_data SHALL hold its last value.
REQ-023 A tag pipeline of ACT_LAT stages (valid bit + channel index) SHALL advance every cycle, aligned with act_in_valid.
REQ-024 When act_out_valid=1, the tag at the pipeline exit SHALL be used as follows: on the next edge, ch_out_valid = onehot(tag) and ch_out_data = act_out_data. In all other cycles ch_out_valid SHALL be 0.
REQ-025 Uncontended latency SHALL be 5 cycles: handshake in cycle 0 gives act_in_valid in cycle 2 and ch_out_valid in cycle 5.
REQ-026 Sustained throughput SHALL be 1 issue per cycle in aggregate, and 1 per 2 cycles per channel.
REQ-027 If act_out_valid=1 while the exiting tag valid bit is 0, err SHALL set and stay set until reset. No ch_out_valid SHALL be produced for that cycle.
REQ-028 If the exiting tag valid bit is 1 while act_out_valid=0, err SHALL set.
REQ-029 Flush SHALL clear all full bits at the next edge and block both grants and ch_in_ready while high. In-flight samples SHALL still complete and be delivered.
REQ-030 Flush and a handshake in the same cycle SHALL be impossible, because ready is low during flush.
REQ-031 idle SHALL be 1 when no full bit is set, no tag valid bit is set, act_in_valid=0 and ch_out_valid=0.
REQ-032 The module SHALL do no arithmetic on the data, which passes through bit-exact.

Reset
REQ-033 While rst_n=1: full=0, last_grant=N_CH-1, tags invalid, act_in_valid=0, act_in_data=0, ch_out_valid=0, ch_out_data=0, err=0, ch_in_ready=0.
REQ-034 Reset mid-operation SHALL drop all buffered and in-flight samples, and no ch_out_valid SHALL follow reset release.
REQ-035 The system SHALL reset the activation unit in the same interval; its reset is active-low and driven by the inverse of the arbiter reset.

Structure
REQ-036 N_CH, ACT_LAT and DATA_W defaults, and the channel-index width $clog2(N_CH), SHALL live in the shared package selu_pkg.
REQ-037 Grant selection SHALL be a sub-module rr_arbiter: combinational round-robin from a request vector and last_grant, producing a one-hot grant and an index.
REQ-038 The activation unit SHALL be instantiated beside this block, not inside it.

Verification
All scenarios use a bench model of the activation unit: 2-cycle delay, f = SELU LUT.
REQ-039 ch2 offers 0x10 in cycle 0 after reset -> act_in 0x10 in cycle 2; ch_out_valid=4'b0100 with f(0x10) in cycle 5.
REQ-040 All 4 channels offer 0x01..0x04 in cycle 0 -> grants in order 0,1,2,3 (act_in in cycles 2..5); outputs one-hot 0001,0010,0100,1000 in cycles 5..8.
REQ-041 ch0 and ch1 stream continuously -> act_in alternates ch0/ch1 every cycle, each channel ready every other cycle, no sample lost or reordered.
REQ-042 Flush with 2 buffered and 2 in flight -> 2 outputs delivered, buffered samples never issued, idle=1 within 4 cycles.
REQ-043 Reset asserted with 3 samples in flight -> all outputs 0 during reset, no ch_out_valid after release, err=0.
REQ-044 Stray act_out_valid pulse with an empty pipeline -> err=1 persisting, no ch_out_valid.
